// File: rtl/cam_udp_packetizer_if.sv
// Signal bundle around the camera UDP packetizer: pixel stream in, transmit-FIFO
// byte stream out, and the length/identification sideband to the GMII transmitter.
interface cam_udp_packetizer_if;
  logic        frame_start;
  logic        frame_end;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic [7:0]  fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic [3:0]  tx_state;
  logic [10:0] frame_index;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic        ovf_err;

  modport master (
    input  frame_start, frame_end, pix_data, pix_valid, fifo_full, tx_state,
    output fifo_din, fifo_wr_en, frame_index, tx_data_length, tx_total_length, ovf_err
  );

  modport slave (
    output frame_start, frame_end, pix_data, pix_valid, fifo_full, tx_state,
    input  fifo_din, fifo_wr_en, frame_index, tx_data_length, tx_total_length, ovf_err
  );
endinterface

// File: rtl/cam_udp_packetizer.sv
// Slices camera frames into fixed-size UDP payloads (8-byte header + pixels + zero pad).
// Define TEST_PATTERN_EN to replace payload pixels with a per-frame byte counter.
module cam_udp_packetizer #(
  parameter int PAYLOAD_BYTES = 1728,
  parameter int HDR_BYTES     = 8,
  parameter int STAGE_DEPTH   = 16
) (
  input logic                  clk,
  input logic                  rst,
  cam_udp_packetizer_if.master bus
);
  localparam int AW = $clog2(STAGE_DEPTH);
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(PAYLOAD_BYTES - 1);
  localparam logic [CW-1:0] LAST_HDR  = CW'(HDR_BYTES - 1);

  typedef enum logic [1:0] {IDLE, HDR, PIX, PAD} state_t;

  state_t        state, state_nx;
  logic [15:0]   frame_num, frame_num_nx;
  logic [15:0]   pkt_num, pkt_num_nx;
  logic [CW-1:0] byte_cnt, byte_cnt_nx;
  logic          end_seen, end_seen_nx;
  logic          wr_go, pop, flush;
  logic [7:0]    wr_byte, hdr_byte, pix_byte;

  logic [7:0]    stage_mem [STAGE_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          empty, full, push_req, push;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(STAGE_DEPTH));
  assign push_req = bus.pix_valid && (state != IDLE);
  assign push     = push_req && !full;

  assign bus.tx_data_length  = 16'(PAYLOAD_BYTES + 8);
  assign bus.tx_total_length = 16'(PAYLOAD_BYTES + 28);

  // NOTE: the staging RAM holds only data qualified by count, so it needs no reset
  // and stays a plain memory rather than a bank of resettable flops.
  always_ff @(posedge clk) begin
    if (push) stage_mem[wr_ptr] <= bus.pix_data;
  end

  // Staging pointers are cleared on each accepted frame_start so stray pixels
  // pushed during padding never leak into the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      bus.ovf_err <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (push_req && full) bus.ovf_err <= 1'b1;
    end
  end

`ifdef TEST_PATTERN_EN
  logic [7:0] pat_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pat_cnt <= 8'd0;
    else if (flush) pat_cnt <= 8'd0;
    else if (pop)   pat_cnt <= pat_cnt + 8'd1;
  end
  assign pix_byte = pat_cnt;
`else
  assign pix_byte = stage_mem[rd_ptr];
`endif

  always_comb begin
    case (byte_cnt[2:0])
      3'd0:    hdr_byte = 8'hA5;
      3'd1:    hdr_byte = {7'd0, pkt_num == 16'd0};
      3'd2:    hdr_byte = frame_num[15:8];
      3'd3:    hdr_byte = frame_num[7:0];
      3'd4:    hdr_byte = pkt_num[15:8];
      3'd5:    hdr_byte = pkt_num[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    frame_num_nx = frame_num;
    pkt_num_nx   = pkt_num;
    byte_cnt_nx  = byte_cnt;
    end_seen_nx  = end_seen || bus.frame_end;
    wr_go        = 1'b0;
    wr_byte      = 8'h00;
    pop          = 1'b0;
    flush        = 1'b0;
    case (state)
      IDLE: begin
        end_seen_nx = 1'b0;
        if (bus.frame_start) begin
          state_nx     = HDR;
          pkt_num_nx   = 16'd0;
          frame_num_nx = frame_num + 16'd1;
          byte_cnt_nx  = '0;
          flush        = 1'b1;
        end
      end
      HDR: begin
        if (!bus.fifo_full) begin
          wr_go       = 1'b1;
          wr_byte     = hdr_byte;
          byte_cnt_nx = byte_cnt + CW'(1);
          if (byte_cnt == LAST_HDR) state_nx = PIX;
        end
      end
      PIX: begin
        if (!empty) begin
          if (!bus.fifo_full) begin
            pop         = 1'b1;
            wr_go       = 1'b1;
            wr_byte     = pix_byte;
            byte_cnt_nx = byte_cnt + CW'(1);
            if (byte_cnt == LAST_BYTE) begin
              pkt_num_nx  = pkt_num + 16'd1;
              byte_cnt_nx = '0;
              state_nx    = HDR;
            end
          end
        end else if (end_seen || bus.frame_end) begin
          // A header with no pixels behind it is still padded out to full length.
          state_nx = PAD;
        end
      end
      PAD: begin
        if (!bus.fifo_full) begin
          wr_go       = 1'b1;
          byte_cnt_nx = byte_cnt + CW'(1);
          if (byte_cnt == LAST_BYTE) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      frame_num      <= 16'd0;
      pkt_num        <= 16'd0;
      byte_cnt       <= '0;
      end_seen       <= 1'b0;
      bus.fifo_wr_en <= 1'b0;
      bus.fifo_din   <= 8'h00;
    end else begin
      state          <= state_nx;
      frame_num      <= frame_num_nx;
      pkt_num        <= pkt_num_nx;
      byte_cnt       <= byte_cnt_nx;
      end_seen       <= end_seen_nx;
      bus.fifo_wr_en <= wr_go;
      if (wr_go) bus.fifo_din <= wr_byte;
    end
  end

  // frame_index advances once per packet, when the transmitter leaves CRC send for idle.
  logic [3:0] tx_state_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q      <= 4'd0;
      bus.frame_index <= 11'd0;
    end else begin
      tx_state_q <= bus.tx_state;
      if (tx_state_q == 4'd7 && bus.tx_state == 4'd0)
        bus.frame_index <= bus.frame_index + 11'd1;
    end
  end
endmodule
